uart_receiver_parity: RTL and testbench

Serial-to-parallel UART receive stage that consumes the single-wire stream produced by the parity UART transmitter. Line format: 1 start bit, 8 data bits LSB first, optional even-parity bit, 1 stop bit. The block recovers each frame using a fixed oversampling clock and presents the byte with parity, framing and overrun status to the host. It holds the byte until the host acknowledges it.

---
 rtl/uart_receiver_parity.sv | 202 ++++++++++++++++++++
 tb/tb_uart_receiver_parity.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver_parity.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver_parity
// Brief    : UART receive stage. The frame is 1 start bit, 8 data bits sent
//            LSB first, an optional even-parity bit and 1 stop bit. Frames
//            are recovered with a fixed oversampling clock. The byte is held
//            with parity, framing and overrun status until the host acks it.
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver_parity #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ack,
  output logic [7:0] dout,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int              c_CW      = $clog2(CLKS_PER_BIT);
  localparam logic [c_CW-1:0] c_LAST    = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_CW-1:0] c_HALF_M1 = c_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CW-1:0] c_ONE     = c_CW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_rx_meta;
  logic            r_rx_s;
  logic [c_CW-1:0] r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_par_bit;
  logic [7:0]      r_dout;
  logic            r_valid;
  logic            r_parity_err;
  logic            r_frame_err;
  logic            r_overrun;

  logic            w_cnt_clr;
  logic            w_bit_clr;
  logic            w_bit_inc;
  logic            w_shift_en;
  logic            w_par_en;
  logic            w_done;
  logic            w_tick;
  logic            w_half;

  assign w_tick = (r_cnt == c_LAST);
  assign w_half = (r_cnt == c_HALF_M1);

  // Two-flop synchronizer; the line idles high so both stages reset to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_bit_clr    = 1'b0;
    w_bit_inc    = 1'b0;
    w_shift_en   = 1'b0;
    w_par_en     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_next = S_START;
          w_cnt_clr    = 1'b1;
        end
      end
      S_START: begin
        if (w_half) begin
          w_cnt_clr = 1'b1;
          if (!r_rx_s) begin
            w_state_next = S_DATA;
            w_bit_clr    = 1'b1;
          end else begin
            // Line went high again before mid-bit: glitch, not a start bit.
            w_state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_en = 1'b1;
          w_cnt_clr  = 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_par_en     = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_done       = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_clr    = 1'b1;
      end
    endcase
  end

  // Bit-timing counter, data bit index, shift register and parity capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_par_bit <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + c_ONE;
      end
      if (w_bit_clr) begin
        r_bit_idx <= 3'd0;
      end else if (w_bit_inc) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_shift_en) begin
        r_shift <= {r_rx_s, r_shift[7:1]};
      end
      if (w_par_en) begin
        r_par_bit <= r_rx_s;
      end
    end
  end

  // Host-facing byte and status; a completing frame takes priority over ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout       <= 8'h00;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_done) begin
      r_dout       <= r_shift;
      r_valid      <= 1'b1;
      r_parity_err <= (PARITY_EN != 0) && (r_par_bit != (^r_shift));
      r_frame_err  <= ~r_rx_s;
      if (r_valid && !ack) begin
        r_overrun <= 1'b1;
      end
    end else if (ack && r_valid) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign valid      = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver_parity.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver_parity
// Brief    : Self-checking bench for uart_receiver_parity. Frames are built
//            from their fields; expected status comes from a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver_parity;

  localparam int c_CPB = 16;
  localparam int c_PEN = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] dout;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Frame-level model of the host-visible state.
  logic [7:0] m_dout    = 8'h00;
  logic       m_valid   = 1'b0;
  logic       m_perr    = 1'b0;
  logic       m_ferr    = 1'b0;
  logic       m_overrun = 1'b0;

  uart_receiver_parity #(
    .CLKS_PER_BIT(c_CPB),
    .PARITY_EN   (c_PEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .ack       (ack),
    .dout      (dout),
    .valid     (valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Even parity bit of a byte, by counting ones.
  function automatic logic even_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return logic'(ones % 2);
  endfunction

  // Model update when a frame completes with no ack on that edge.
  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
    if (m_valid) m_overrun = 1'b1;
    m_valid = 1'b1;
    m_dout  = d;
    m_perr  = (c_PEN != 0) && (par != even_par(d));
    m_ferr  = ~stop;
  endtask

  // Drive one frame after `gap` idle bit-cycles on the line.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx = 1'b0;
    repeat (c_CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (c_CPB) @(negedge clk);
    end
    if (c_PEN != 0) begin
      rx = par;
      repeat (c_CPB) @(negedge clk);
    end
    rx = stop;
    repeat (c_CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    if (m_valid) begin
      m_valid   = 1'b0;
      m_overrun = 1'b0;
    end
  endtask

  task automatic compare_all(input string name);
    checks++;
    if (dout !== m_dout) begin
      errors++;
      $display("FAIL %s dout: got %h expected %h", name, dout, m_dout);
    end
    checks++;
    if (valid !== m_valid) begin
      errors++;
      $display("FAIL %s valid: got %b expected %b", name, valid, m_valid);
    end
    checks++;
    if (parity_err !== m_perr) begin
      errors++;
      $display("FAIL %s parity_err: got %b expected %b", name, parity_err, m_perr);
    end
    checks++;
    if (frame_err !== m_ferr) begin
      errors++;
      $display("FAIL %s frame_err: got %b expected %b", name, frame_err, m_ferr);
    end
    checks++;
    if (overrun !== m_overrun) begin
      errors++;
      $display("FAIL %s overrun: got %b expected %b", name, overrun, m_overrun);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    compare_all("reset");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset busy: got %b expected 0", busy);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // 0xA5 with correct parity; checks busy rise and the valid rise cycle.
  task automatic test_timing();
    logic [7:0] d = 8'hA5;
    fork
      send_frame(d, even_par(d), 1'b1, 0);
      begin
        @(negedge clk);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL timing busy_c0: got %b expected 0", busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL timing busy_c1: got %b expected 1", busy);
        end
        repeat (167) @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("FAIL timing valid_c168: got %b expected 0", valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL timing valid_c169: got valid=%b busy=%b expected valid=1 busy=0", valid, busy);
        end
      end
    join
    model_frame(d, even_par(d), 1'b1);
    compare_all("timing_a5");
    pulse_ack();
    compare_all("timing_ack");
  endtask

  task automatic test_parity_error();
    logic [7:0] d = 8'hA5;
    send_frame(d, ~even_par(d), 1'b1, 2 * c_CPB);
    model_frame(d, ~even_par(d), 1'b1);
    compare_all("parity_err_a5");
    pulse_ack();
  endtask

  task automatic test_frame_error();
    logic [7:0] d = 8'h3C;
    send_frame(d, even_par(d), 1'b0, 2 * c_CPB);
    model_frame(d, even_par(d), 1'b0);
    compare_all("frame_err_3c");
    pulse_ack();
    d = 8'h00;
    send_frame(d, even_par(d), 1'b1, 2 * c_CPB);
    model_frame(d, even_par(d), 1'b1);
    compare_all("after_frame_err_00");
    pulse_ack();
  endtask

  // A 4-cycle low pulse must be rejected as a false start.
  task automatic test_false_start();
    bit saw_busy = 0;
    repeat (2 * c_CPB) @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 4 * c_CPB; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
    end
    checks++;
    if (!saw_busy) begin
      errors++;
      $display("FAIL false_start busy_pulse: got 0 expected 1");
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL false_start busy_end: got %b expected 0", busy);
    end
    compare_all("false_start");
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, even_par(8'h11), 1'b1, 2 * c_CPB);
    model_frame(8'h11, even_par(8'h11), 1'b1);
    send_frame(8'h22, even_par(8'h22), 1'b1, 0);
    model_frame(8'h22, even_par(8'h22), 1'b1);
    compare_all("b2b_22");
    pulse_ack();
    compare_all("b2b_ack");
  endtask

  // Ack on the same edge as completion: new byte loads, valid stays, no overrun.
  task automatic test_ack_collision();
    send_frame(8'h5C, even_par(8'h5C), 1'b1, 2 * c_CPB);
    model_frame(8'h5C, even_par(8'h5C), 1'b1);
    fork
      send_frame(8'hC3, even_par(8'hC3), 1'b1, 0);
      begin
        @(negedge clk);
        repeat (170) @(posedge clk);
        #1;
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
      end
    join
    m_valid   = 1'b1;
    m_dout    = 8'hC3;
    m_perr    = 1'b0;
    m_ferr    = 1'b0;
    m_overrun = 1'b0;
    compare_all("ack_collision");
    pulse_ack();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d = 8'h5A;
    repeat (2 * c_CPB) @(negedge clk);
    rx = 1'b0;
    repeat (c_CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (c_CPB) @(negedge clk);
    end
    rx  = 1'b1;
    rst = 1'b0;
    m_dout = 8'h00; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_overrun = 1'b0;
    repeat (3) @(negedge clk);
    compare_all("midframe_in_reset");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midframe busy: got %b expected 0", busy);
    end
    rst = 1'b1;
    repeat (6 * c_CPB) @(negedge clk);
    compare_all("midframe_after_release");
    d = 8'h96;
    send_frame(d, even_par(d), 1'b1, 2 * c_CPB);
    model_frame(d, even_par(d), 1'b1);
    compare_all("midframe_96");
    pulse_ack();
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d    = 8'($urandom);
      logic       bad  = ($urandom_range(3) == 0);
      logic       stop = ($urandom_range(4) != 0);
      logic       skip = ($urandom_range(2) == 0);
      logic       par  = even_par(d) ^ bad;
      send_frame(d, par, stop, 2 * c_CPB);
      model_frame(d, par, stop);
      compare_all($sformatf("random_%0d", n));
      if (!skip) pulse_ack();
    end
    pulse_ack();
    compare_all("random_final_ack");
  endtask

  initial begin
    test_reset();
    test_timing();
    test_parity_error();
    test_frame_error();
    test_false_start();
    test_back_to_back();
    test_ack_collision();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
